// File: rtl/fsm_aire.sv
// Air-conditioner front-panel controller: a four-state menu FSM plus
// edge-detected buttons that adjust stored fan speed and temperature range.
module fsm_aire (
  input  logic       clock,
  input  logic       reset,
  input  logic       ON,
  input  logic       PB1,
  input  logic       PB2,
  input  logic       PB3,
  input  logic       PB4,
  input  logic [2:0] Ok,
  output logic [1:0] Led1,
  output logic [1:0] LCD1,
  output logic [2:0] LCD2,
  output logic [2:0] Led2
);

  // State codes double as the Led1 display encoding.
  localparam logic [1:0] ST_OFF   = 2'b00;
  localparam logic [1:0] ST_HOME  = 2'b01;
  localparam logic [1:0] ST_SPEED = 2'b10;
  localparam logic [1:0] ST_TEMP  = 2'b11;

  localparam logic [1:0] SPD_LOW  = 2'b01;
  localparam logic [1:0] SPD_HIGH = 2'b11;
  localparam logic [2:0] TMP_MIN  = 3'd1;
  localparam logic [2:0] TMP_MAX  = 3'd4;

  logic [1:0] r_state;
  logic [1:0] r_speed;
  logic [2:0] r_temp;
  logic [3:0] r_pb_prev;
  logic [1:0] r_led1;
  logic [1:0] r_lcd1;
  logic [2:0] r_lcd2;
  logic [2:0] r_led2;

  logic [1:0] w_next_state;
  logic [1:0] w_speed_nxt;
  logic [2:0] w_temp_nxt;
  logic [3:0] w_pb;
  logic [3:0] w_edge;

  assign w_pb   = {PB4, PB3, PB2, PB1};
  assign w_edge = w_pb & ~r_pb_prev;

  always_comb begin
    w_next_state = r_state;
    if (!ON) begin
      w_next_state = ST_OFF;
    end else begin
      case (r_state)
        ST_OFF:   w_next_state = ST_HOME;
        ST_HOME: begin
          if (Ok[2])                w_next_state = ST_HOME;
          else if (Ok[1:0] == 2'b00) w_next_state = ST_SPEED;
          else                      w_next_state = ST_TEMP;
        end
        ST_SPEED: begin
          if (Ok[2])                w_next_state = ST_HOME;
          else if (Ok[1:0] == 2'b10) w_next_state = ST_TEMP;
          else                      w_next_state = ST_SPEED;
        end
        ST_TEMP: begin
          if (Ok[2])      w_next_state = ST_HOME;
          else if (Ok[0]) w_next_state = ST_SPEED;
          else            w_next_state = ST_TEMP;
        end
        default: w_next_state = ST_OFF;
      endcase
    end
  end

  // Settings move only when the menu being entered or held owns them;
  // simultaneous up+down edges cancel.
  always_comb begin
    w_speed_nxt = r_speed;
    if (w_next_state == ST_SPEED) begin
      if (w_edge[0] && !w_edge[1] && r_speed != SPD_HIGH)
        w_speed_nxt = r_speed + 2'd1;
      else if (w_edge[1] && !w_edge[0] && r_speed != SPD_LOW)
        w_speed_nxt = r_speed - 2'd1;
    end
  end

  always_comb begin
    w_temp_nxt = r_temp;
    if (w_next_state == ST_TEMP) begin
      if (w_edge[2] && !w_edge[3] && r_temp != TMP_MAX)
        w_temp_nxt = r_temp + 3'd1;
      else if (w_edge[3] && !w_edge[2] && r_temp != TMP_MIN)
        w_temp_nxt = r_temp - 3'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= ST_OFF;
      r_speed   <= SPD_LOW;
      r_temp    <= TMP_MIN;
      r_pb_prev <= 4'b0000;
      r_led1    <= 2'b00;
      r_lcd1    <= 2'b00;
      r_lcd2    <= 3'b000;
      r_led2    <= 3'b000;
    end else begin
      r_state   <= w_next_state;
      r_speed   <= w_speed_nxt;
      r_temp    <= w_temp_nxt;
      r_pb_prev <= w_pb;
      r_led1    <= w_next_state;
      // Displays blank in OFF; stored settings are kept regardless.
      if (w_next_state == ST_OFF) begin
        r_lcd1 <= 2'b00;
        r_lcd2 <= 3'b000;
        r_led2 <= 3'b000;
      end else begin
        r_lcd1 <= w_speed_nxt;
        r_lcd2 <= w_temp_nxt;
        r_led2 <= w_temp_nxt;
      end
    end
  end

  assign Led1 = r_led1;
  assign LCD1 = r_lcd1;
  assign LCD2 = r_lcd2;
  assign Led2 = r_led2;

endmodule

// File: tb/tb_fsm_aire.sv
// Directed bench for fsm_aire: menu navigation, button edges, saturation,
// retention through OFF and reset behaviour, with hand-computed expectations.
module tb_fsm_aire;

  logic       clock;
  logic       reset;
  logic       ON;
  logic       PB1, PB2, PB3, PB4;
  logic [2:0] Ok;
  logic [1:0] Led1;
  logic [1:0] LCD1;
  logic [2:0] LCD2;
  logic [2:0] Led2;

  int n_checks;
  int n_errors;

  fsm_aire dut (
    .clock (clock),
    .reset (reset),
    .ON    (ON),
    .PB1   (PB1),
    .PB2   (PB2),
    .PB3   (PB3),
    .PB4   (PB4),
    .Ok    (Ok),
    .Led1  (Led1),
    .LCD1  (LCD1),
    .LCD2  (LCD2),
    .Led2  (Led2)
  );

  // Clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [1:0] led1, input logic [1:0] lcd1,
                           input logic [2:0] lcd2, input logic [2:0] led2);
    check({tag, ".Led1"}, {6'd0, Led1}, {6'd0, led1});
    check({tag, ".LCD1"}, {6'd0, LCD1}, {6'd0, lcd1});
    check({tag, ".LCD2"}, {5'd0, LCD2}, {5'd0, lcd2});
    check({tag, ".Led2"}, {5'd0, Led2}, {5'd0, led2});
  endtask

  task automatic pulse(input int which);
    PB1 = (which == 1);
    PB2 = (which == 2);
    PB3 = (which == 3);
    PB4 = (which == 4);
    step();
  endtask

  task automatic release_all();
    PB1 = 0; PB2 = 0; PB3 = 0; PB4 = 0;
    step();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 0; ON = 0; Ok = 3'b000;
    PB1 = 0; PB2 = 0; PB3 = 0; PB4 = 0;
    step(); step();
    check_all("reset", 2'b00, 2'b00, 3'b000, 3'b000);

    // Power on -> HOME with defaults, then SPEED
    reset = 1; ON = 1; Ok = 3'b000;
    step();
    check_all("home", 2'b01, 2'b01, 3'b001, 3'b001);
    step();
    check("to_speed.Led1", {6'd0, Led1}, 8'h02);

    // Speed up with saturation, then down
    pulse(1); check("spd_up1", {6'd0, LCD1}, 8'h02); release_all();
    pulse(1); check("spd_up2", {6'd0, LCD1}, 8'h03); release_all();
    pulse(1); check("spd_sat", {6'd0, LCD1}, 8'h03); release_all();
    pulse(2); check("spd_dn",  {6'd0, LCD1}, 8'h02); release_all();
    PB1 = 1; PB2 = 1; step();
    check("spd_both", {6'd0, LCD1}, 8'h02);
    release_all();
    check("spd_stay.Led1", {6'd0, Led1}, 8'h02);

    // SPEED -> TEMP, temperature up x3 plus saturation, down x2
    Ok = 3'b010; step();
    check("to_temp.Led1", {6'd0, Led1}, 8'h03);
    Ok = 3'b000;
    pulse(3); check("tmp_up1", {5'd0, LCD2}, 8'h02); release_all();
    pulse(3); check("tmp_up2", {5'd0, LCD2}, 8'h03); release_all();
    pulse(3); check_all("tmp_up3", 2'b11, 2'b10, 3'b100, 3'b100); release_all();
    pulse(3); check_all("tmp_sat", 2'b11, 2'b10, 3'b100, 3'b100); release_all();
    pulse(4); check("tmp_dn1", {5'd0, Led2}, 8'h03); release_all();
    pulse(4); check_all("tmp_dn2", 2'b11, 2'b10, 3'b010, 3'b010); release_all();
    PB3 = 1; PB4 = 1; step();
    check("tmp_both", {5'd0, LCD2}, 8'h02);
    release_all();

    // TEMP -> HOME; same-edge entry and adjust
    Ok = 3'b100; step();
    check("temp_home.Led1", {6'd0, Led1}, 8'h01);
    Ok = 3'b001; PB3 = 1; step();
    check_all("home_temp_up", 2'b11, 2'b10, 3'b011, 3'b011);
    Ok = 3'b000; PB3 = 0; step();
    Ok = 3'b011; PB1 = 1; step();
    check_all("temp_speed_up", 2'b10, 2'b11, 3'b011, 3'b011);
    Ok = 3'b000; PB1 = 0; step();

    // PB3 in SPEED ignored; PB2 steps speed down
    pulse(3); check("spd_pb3_ign", {5'd0, LCD2}, 8'h03); release_all();
    pulse(2); check("spd_dn2", {6'd0, LCD1}, 8'h02); release_all();

    // OFF blanks everything; presses while off are ignored; settings retained
    ON = 0; step();
    check_all("off", 2'b00, 2'b00, 3'b000, 3'b000);
    pulse(1); check_all("off_press", 2'b00, 2'b00, 3'b000, 3'b000); release_all();
    Ok = 3'b100; ON = 1; step();
    check_all("on_retained", 2'b01, 2'b10, 3'b011, 3'b011);

    // Press in HOME is not queued for TEMP
    pulse(3); release_all();
    Ok = 3'b001; step();
    check_all("no_queue", 2'b11, 2'b10, 3'b011, 3'b011);

    // Held PB1 gives exactly one step
    Ok = 3'b011; step();
    check("held_entry.Led1", {6'd0, Led1}, 8'h02);
    Ok = 3'b000;
    pulse(2); check("held_pre", {6'd0, LCD1}, 8'h01); release_all();
    PB1 = 1;
    step(); check("held1", {6'd0, LCD1}, 8'h02);
    step(); check("held2", {6'd0, LCD1}, 8'h02);
    step(); check("held3", {6'd0, LCD1}, 8'h02);
    release_all();

    // Reset in TEMP with a button held; held across release is not a press
    Ok = 3'b010; step();
    check("pre_rst.Led1", {6'd0, Led1}, 8'h03);
    Ok = 3'b000; PB3 = 1; reset = 0; step();
    check_all("rst_temp", 2'b00, 2'b00, 3'b000, 3'b000);
    reset = 1; step();
    check_all("rst_home", 2'b01, 2'b01, 3'b001, 3'b001);
    Ok = 3'b001; step();
    check_all("rst_held", 2'b11, 2'b01, 3'b001, 3'b001);
    release_all();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
